pad_mux_sequencer: RTL and testbench



---
 rtl/pad_mux_pkg.sv | 28 ++
 rtl/pad_guard_timer.sv | 35 +++
 rtl/pad_mux_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pad_mux_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_mux_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : pad_mux_pkg                                                      |
// | Brief   : Shared constants and sequencer state type for the pad mux.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pad_mux_pkg;

    localparam int NUM_PADS  = 44;
    localparam int NUM_FUNCS = 4;
    localparam int FUNC_W    = $clog2(NUM_FUNCS);

    // Pads carrying the chip clock and reset are never handed to a peripheral
    localparam int CLK_PAD = 38;
    localparam int RST_PAD = 40;
    localparam logic [NUM_PADS-1:0] LOCKED_MASK =
        (NUM_PADS'(1) << CLK_PAD) | (NUM_PADS'(1) << RST_PAD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/pad_guard_timer.sv
// +----------------------------------------------------------------------------+
// | Module  : pad_guard_timer                                                  |
// | Brief   : Loadable down-counter; done is high whenever the count is zero.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pad_guard_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pad_mux_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : pad_mux_sequencer                                                |
// | Brief   : Runtime pin-mux with break-before-make function switching.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pad_mux_sequencer #(
    parameter int NUM_PADS     = 44,
    parameter int NUM_FUNCS    = 4,
    parameter int FUNC_W       = $clog2(NUM_FUNCS),
    parameter int GUARD_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [5:0]                    cfg_pad,
    input  logic [FUNC_W-1:0]             cfg_func,
    output logic                          busy,
    output logic [NUM_PADS*FUNC_W-1:0]    pad_sel,
    input  logic [NUM_FUNCS*NUM_PADS-1:0] periph_o,
    input  logic [NUM_FUNCS*NUM_PADS-1:0] periph_oe,
    output logic [NUM_FUNCS*NUM_PADS-1:0] periph_i,
    input  logic [NUM_PADS-1:0]           gpio_in,
    output logic [NUM_PADS-1:0]           gpio_out,
    output logic [NUM_PADS-1:0]           gpio_oeb
);

    import pad_mux_pkg::LOCKED_MASK;
    import pad_mux_pkg::seq_state_t;
    import pad_mux_pkg::IDLE;
    import pad_mux_pkg::DRAIN;
    import pad_mux_pkg::SWITCH;

    localparam int                c_CNT_W      = $clog2(GUARD_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LOAD = c_CNT_W'(GUARD_CYCLES - 1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [5:0]          r_tgt_pad;
    logic [FUNC_W-1:0]   r_tgt_func;
    logic [FUNC_W-1:0]   r_pad_sel [NUM_PADS];

    logic                w_accept;
    logic                w_commit;
    logic                w_hold;
    logic                w_done;
    logic                w_drop;
    logic                w_pad_locked;
    logic [FUNC_W-1:0]   w_cur_func;
    logic [NUM_PADS-1:0] w_out_nxt;
    logic [NUM_PADS-1:0] w_oeb_nxt;

    // Out-of-range pad indices fall through the loop and read as unlocked func 0
    always_comb begin
        w_cur_func   = '0;
        w_pad_locked = 1'b0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (cfg_pad == 6'(p)) begin
                w_cur_func   = r_pad_sel[p];
                w_pad_locked = LOCKED_MASK[p];
            end
        end
        w_drop = (32'(cfg_pad) >= NUM_PADS) || w_pad_locked ||
                 (32'(cfg_func) >= NUM_FUNCS) || (cfg_func == w_cur_func);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cfg_valid && !w_drop) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_done) begin
                    w_state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tgt_pad  <= '0;
            r_tgt_func <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tgt_pad  <= cfg_pad;
                r_tgt_func <= cfg_func;
            end
        end
    end

    pad_guard_timer #(
        .WIDTH (c_CNT_W)
    ) u_guard_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept),
        .load_val (c_GUARD_LOAD),
        .dec      (r_state == DRAIN),
        .done     (w_done)
    );

    assign cfg_ready = (r_state == IDLE) && !rst;
    assign busy      = (r_state != IDLE);
    assign w_hold    = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                r_pad_sel[p] <= '0;
            end
            gpio_out <= '0;
            gpio_oeb <= '1;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (w_commit && (r_tgt_pad == 6'(p))) begin
                    r_pad_sel[p] <= r_tgt_func;
                end
            end
            gpio_out <= w_out_nxt;
            gpio_oeb <= w_oeb_nxt;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [FUNC_W-1:0]    w_sel;
        logic                 w_force;
        logic [NUM_FUNCS-1:0] w_fo;
        logic [NUM_FUNCS-1:0] w_foe;

        assign w_sel                        = r_pad_sel[p];
        assign pad_sel[p*FUNC_W +: FUNC_W]  = w_sel;
        // The draining pad stays tristated until its new owner is committed
        assign w_force = LOCKED_MASK[p] | (w_hold & (r_tgt_pad == 6'(p)));

        for (genvar f = 0; f < NUM_FUNCS; f++) begin : g_func
            assign w_fo[f]                   = periph_o[f*NUM_PADS + p];
            assign w_foe[f]                  = periph_oe[f*NUM_PADS + p];
            assign periph_i[f*NUM_PADS + p]  = gpio_in[p] & (w_sel == FUNC_W'(f));
        end

        assign w_out_nxt[p] = ~w_force & w_fo[w_sel];
        assign w_oeb_nxt[p] = w_force | ~w_foe[w_sel];
    end

endmodule

`default_nettype wire

// File: tb/tb_pad_mux_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_pad_mux_sequencer                                             |
// | Brief   : Directed bench with a timeline-based reference model.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pad_mux_sequencer;

    localparam int NP = 44;
    localparam int NF = 4;
    localparam int FW = 2;
    localparam int G  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [5:0]      cfg_pad;
    logic [FW-1:0]   cfg_func;
    logic            busy;
    logic [NP*FW-1:0] pad_sel;
    logic [NF*NP-1:0] periph_o;
    logic [NF*NP-1:0] periph_oe;
    logic [NF*NP-1:0] periph_i;
    logic [NP-1:0]   gpio_in;
    logic [NP-1:0]   gpio_out;
    logic [NP-1:0]   gpio_oeb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pad_mux_sequencer #(
        .NUM_PADS     (NP),
        .NUM_FUNCS    (NF),
        .FUNC_W       (FW),
        .GUARD_CYCLES (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_pad   (cfg_pad),
        .cfg_func  (cfg_func),
        .busy      (busy),
        .pad_sel   (pad_sel),
        .periph_o  (periph_o),
        .periph_oe (periph_oe),
        .periph_i  (periph_i),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb)
    );

    task automatic chk(input string nm, input logic [NF*NP-1:0] act, input logic [NF*NP-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: a request accepted in cycle T owns the timeline
    // T+1..T+G+1 (pad held off), and the new function becomes visible at T+G+2.
    int          m_sel [NP];
    logic [NP-1:0] m_out;
    logic [NP-1:0] m_oeb;
    int          acc_t = -1;
    int          m_tgt;
    int          m_tfunc;
    bit          m_valid = 1'b0;
    int          cyc = 0;

    function automatic bit in_window(input int n);
        return (acc_t >= 0) && (n >= acc_t + 1) && (n <= acc_t + G + 1);
    endfunction

    always @(negedge clk) begin : model_cmp
        logic [NP-1:0]    nout;
        logic [NP-1:0]    noeb;
        logic [NF*NP-1:0] epi;
        logic [NP*FW-1:0] esel;
        bit               bz;
        bit               drop;
        bit               forced;
        int               s;
        int               pd;
        int               fn;

        bz = in_window(cyc);
        if (m_valid) begin
            for (int p = 0; p < NP; p++) begin
                esel[p*FW +: FW] = FW'(m_sel[p]);
                for (int f = 0; f < NF; f++) begin
                    epi[f*NP + p] = gpio_in[p] & (m_sel[p] == f);
                end
            end
            chk("cfg_ready", {175'd0, cfg_ready}, {175'd0, (!rst && !bz)});
            chk("busy", {175'd0, busy}, {175'd0, bz});
            chk("pad_sel", {88'd0, pad_sel}, {88'd0, esel});
            chk("gpio_out", {132'd0, gpio_out}, {132'd0, m_out});
            chk("gpio_oeb", {132'd0, gpio_oeb}, {132'd0, m_oeb});
            chk("periph_i", periph_i, epi);
        end

        if (rst) begin
            for (int p = 0; p < NP; p++) m_sel[p] = 0;
            m_out   = '0;
            m_oeb   = '1;
            acc_t   = -1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int p = 0; p < NP; p++) begin
                s      = m_sel[p];
                forced = (p == 38) || (p == 40) || (bz && (p == m_tgt));
                nout[p] = forced ? 1'b0 : periph_o[s*NP + p];
                noeb[p] = forced ? 1'b1 : ~periph_oe[s*NP + p];
            end
            m_out = nout;
            m_oeb = noeb;
            if ((acc_t >= 0) && (cyc == acc_t + G + 1)) begin
                m_sel[m_tgt] = m_tfunc;
            end
            if (cfg_valid && !bz) begin
                pd   = int'(cfg_pad);
                fn   = int'(cfg_func);
                drop = 1'b0;
                if (pd >= NP || pd == 38 || pd == 40 || fn >= NF) drop = 1'b1;
                else if (m_sel[pd] == fn) drop = 1'b1;
                if (!drop) begin
                    acc_t   = cyc;
                    m_tgt   = pd;
                    m_tfunc = fn;
                end
            end
        end
        cyc++;
    end

    // Advance to the next cycle; func 0 data toggles every cycle on all pads
    task automatic step();
        @(posedge clk);
        #1;
        periph_o[NP-1:0] = ~periph_o[NP-1:0];
        gpio_in = NP'({$urandom(), $urandom()});
    endtask

    initial begin : stim
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_pad   = '0;
        cfg_func  = '0;
        periph_o  = '0;
        periph_oe = '0;
        gpio_in   = '0;

        repeat (3) step();
        @(negedge clk);
        chk("rst_cfg_ready", {175'd0, cfg_ready}, 176'd0);
        chk("rst_gpio_oeb", {132'd0, gpio_oeb}, {132'd0, {NP{1'b1}}});
        chk("rst_gpio_out", {132'd0, gpio_out}, 176'd0);
        chk("rst_pad_sel", {88'd0, pad_sel}, 176'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {175'd0, cfg_ready}, 176'd1);

        // funcs 0 and 2 enable their outputs; func 2 drives ones, func 3 alternates
        periph_oe = {{NP{1'b0}}, {NP{1'b1}}, {NP{1'b0}}, {NP{1'b1}}};
        periph_o[2*NP +: NP] = '1;
        periph_o[1*NP +: NP] = '0;
        periph_o[3*NP +: NP] = {(NP/2){2'b10}};
        step();
        step();

        // Pad 10 -> func 2, accepted in cycle T
        step();
        cfg_valid = 1'b1; cfg_pad = 6'd10; cfg_func = 2'd2;
        @(negedge clk);
        chk("t0_ready", {175'd0, cfg_ready}, 176'd1);
        step();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("t1_busy", {175'd0, busy}, 176'd1);
        chk("t1_oeb10", {175'd0, gpio_oeb[10]}, 176'd0);
        for (int k = 2; k <= 6; k++) begin
            step();
            @(negedge clk);
            chk("guard_oeb10", {175'd0, gpio_oeb[10]}, 176'd1);
            if (k == 5) chk("t5_sel10", {174'd0, pad_sel[10*FW +: FW]}, 176'd0);
            if (k == 6) begin
                chk("t6_sel10", {174'd0, pad_sel[10*FW +: FW]}, 176'd2);
                chk("t6_ready", {175'd0, cfg_ready}, 176'd1);
            end
        end
        step();
        gpio_in[10] = 1'b1;
        @(negedge clk);
        chk("t7_oeb10", {175'd0, gpio_oeb[10]}, 176'd0);
        chk("t7_out10", {175'd0, gpio_out[10]}, 176'd1);
        chk("t7_pi_f2", {175'd0, periph_i[2*NP + 10]}, 176'd1);
        chk("t7_pi_f0", {175'd0, periph_i[10]}, 176'd0);

        // Dropped requests: redundant, locked clk pad, out of range, locked rst pad
        step();
        cfg_valid = 1'b1; cfg_pad = 6'd10; cfg_func = 2'd2;
        @(negedge clk);
        chk("redund_ready", {175'd0, cfg_ready}, 176'd1);
        step();
        cfg_pad = 6'd38; cfg_func = 2'd1;
        @(negedge clk);
        chk("redund_busy", {175'd0, busy}, 176'd0);
        step();
        cfg_pad = 6'd50;
        @(negedge clk);
        chk("pad38_busy", {175'd0, busy}, 176'd0);
        step();
        cfg_pad = 6'd40; cfg_func = 2'd3;
        @(negedge clk);
        chk("pad50_busy", {175'd0, busy}, 176'd0);

        // Pad 5 accepted at T2, then a held request for pad 6 waits for ready
        step();
        cfg_pad = 6'd5; cfg_func = 2'd1;
        @(negedge clk);
        chk("t2_ready", {175'd0, cfg_ready}, 176'd1);
        chk("t2_busy", {175'd0, busy}, 176'd0);
        chk("t2_sel10", {174'd0, pad_sel[10*FW +: FW]}, 176'd2);
        step();
        cfg_pad = 6'd6; cfg_func = 2'd3;
        @(negedge clk);
        chk("t2p1_ready", {175'd0, cfg_ready}, 176'd0);
        for (int k = 2; k <= 5; k++) begin
            step();
            @(negedge clk);
            chk("held_ready", {175'd0, cfg_ready}, 176'd0);
        end
        step();
        @(negedge clk);
        chk("t2p6_ready", {175'd0, cfg_ready}, 176'd1);
        chk("t2p6_sel5", {174'd0, pad_sel[5*FW +: FW]}, 176'd1);
        step();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("t3p1_busy", {175'd0, busy}, 176'd1);

        // Reset at T3+3 of the pad 6 sequence
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {175'd0, cfg_ready}, 176'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_busy", {175'd0, busy}, 176'd0);
        chk("postrst_sel", {88'd0, pad_sel}, 176'd0);
        chk("postrst_oeb6", {175'd0, gpio_oeb[6]}, 176'd1);
        chk("postrst_ready", {175'd0, cfg_ready}, 176'd1);
        repeat (4) step();
        @(negedge clk);
        chk("no_partial_sel6", {174'd0, pad_sel[6*FW +: FW]}, 176'd0);

        // One more full sequence after reset
        step();
        cfg_valid = 1'b1; cfg_pad = 6'd7; cfg_func = 2'd3;
        step();
        cfg_valid = 1'b0;
        repeat (G + 3) step();
        @(negedge clk);
        chk("final_sel7", {174'd0, pad_sel[7*FW +: FW]}, 176'd3);
        step();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
